// File: rtl/nanov_regfile_serial.sv
// Digit-serial register file for nanoV: each XLEN-bit register is streamed
// DIGIT bits per cycle, LSB digit first, in step with an internal digit counter.
module nanov_regfile_serial #(
    parameter int XLEN     = 32,
    parameter int DIGIT    = 1,
    parameter int NUM_REGS = 16,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int CW       = ((XLEN / DIGIT) > 1) ? $clog2(XLEN / DIGIT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             wr_en,
    input  logic             read_through,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    rd,
    input  logic [DIGIT-1:0] rd_in,
    output logic [DIGIT-1:0] rs1_out,
    output logic [DIGIT-1:0] rs2_out,
    output logic [CW-1:0]    digit_idx,
    output logic             word_start,
    output logic             word_done
);

    localparam int N = XLEN / DIGIT;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] idx_reg;
    logic [CW-1:0] idx_next;
    logic          wr_fire;

    always_comb begin
        idx_next = idx_reg;
        if (!hold) begin
            idx_next = (idx_reg == LAST) ? '0 : idx_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg <= '0;
        end else begin
            idx_reg <= idx_next;
        end
    end

    assign digit_idx  = idx_reg;
    assign word_start = (idx_reg == '0);
    assign word_done  = (idx_reg == LAST);

    assign wr_fire = wr_en && !hold && (rd != '0);

    // Entry 0 is a constant zero word; only x1..x(NUM_REGS-1) hold state.
    logic [XLEN-1:0] words [NUM_REGS];
    assign words[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [XLEN-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (wr_fire && (rd == AW'(gi))) begin
                    for (int k = 0; k < N; k++) begin
                        if (idx_reg == CW'(k)) begin
                            word_reg[k*DIGIT +: DIGIT] <= rd_in;
                        end
                    end
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    // Two identical read ports; index 0 is rs1, index 1 is rs2.
    logic [AW-1:0]    rs_addr  [2];
    logic [DIGIT-1:0] rs_digit [2];

    assign rs_addr[0] = rs1;
    assign rs_addr[1] = rs2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            logic            in_range;
            logic            bypass;
            logic [XLEN-1:0] word_sel;
            logic [DIGIT-1:0] digs [N];

            assign in_range = (int'(rs_addr[gi]) < NUM_REGS);
            assign word_sel = in_range ? words[rs_addr[gi]] : '0;
            assign bypass   = read_through && wr_fire && (rs_addr[gi] == rd);

            genvar gd;
            for (gd = 0; gd < N; gd++) begin : g_dig
                assign digs[gd] = word_sel[gd*DIGIT +: DIGIT];
            end

            assign rs_digit[gi] = bypass ? rd_in : digs[idx_reg];
        end
    endgenerate

    assign rs1_out = rs_digit[0];
    assign rs2_out = rs_digit[1];

endmodule

// File: tb/tb_nanov_regfile_serial.sv
// Directed bench for nanov_regfile_serial: a vector table for the nibble-serial
// instance plus hand sequences for hold, mid-word reset and the width sweep.
module tb_nanov_regfile_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: XLEN=32, DIGIT=4, NUM_REGS=16
    logic       a_rst, a_hold, a_wr, a_rt;
    logic [3:0] a_rs1, a_rs2, a_rd, a_in, a_o1, a_o2;
    logic [2:0] a_idx;
    logic       a_start, a_done;

    nanov_regfile_serial #(.XLEN(32), .DIGIT(4), .NUM_REGS(16)) dut_a (
        .clk(clk), .rst(a_rst), .hold(a_hold), .wr_en(a_wr), .read_through(a_rt),
        .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .rd_in(a_in),
        .rs1_out(a_o1), .rs2_out(a_o2), .digit_idx(a_idx),
        .word_start(a_start), .word_done(a_done)
    );

    // Instance B: DIGIT=1, N=32, NUM_REGS=32
    logic       b_rst, b_wr;
    logic [4:0] b_rs1, b_rd, b_idx;
    logic       b_in, b_o1, b_o2, b_start, b_done;

    nanov_regfile_serial #(.XLEN(32), .DIGIT(1), .NUM_REGS(32)) dut_b (
        .clk(clk), .rst(b_rst), .hold(1'b0), .wr_en(b_wr), .read_through(1'b0),
        .rs1(b_rs1), .rs2(5'd0), .rd(b_rd), .rd_in(b_in),
        .rs1_out(b_o1), .rs2_out(b_o2), .digit_idx(b_idx),
        .word_start(b_start), .word_done(b_done)
    );

    // Instance C: DIGIT=8, N=4, NUM_REGS=32
    logic       c_rst, c_wr;
    logic [4:0] c_rs1, c_rd;
    logic [7:0] c_in, c_o1, c_o2;
    logic [1:0] c_idx;
    logic       c_start, c_done;

    nanov_regfile_serial #(.XLEN(32), .DIGIT(8), .NUM_REGS(32)) dut_c (
        .clk(clk), .rst(c_rst), .hold(1'b0), .wr_en(c_wr), .read_through(1'b0),
        .rs1(c_rs1), .rs2(5'd0), .rd(c_rd), .rd_in(c_in),
        .rs1_out(c_o1), .rs2_out(c_o2), .digit_idx(c_idx),
        .word_start(c_start), .word_done(c_done)
    );

    typedef struct {
        logic       wr;
        logic       rt;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] din;
        logic [3:0] e1;
        logic [3:0] e2;
        logic [2:0] eidx;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [3:0] dig(input logic [31:0] w, input int k);
        return w[k*4 +: 4];
    endfunction

    function automatic void add(input logic wr, input logic rt,
                                input logic [3:0] r1, input logic [3:0] r2,
                                input logic [3:0] rdd, input logic [3:0] din,
                                input logic [3:0] e1, input logic [3:0] e2,
                                input int k);
        vec_t v;
        v.wr = wr; v.rt = rt; v.rs1 = r1; v.rs2 = r2; v.rd = rdd;
        v.din = din; v.e1 = e1; v.e2 = e2; v.eidx = 3'(k);
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, i, act, exp);
        end
    endtask

    task automatic step_a(input logic r, input logic h, input logic w, input logic t,
                          input logic [3:0] r1, input logic [3:0] r2,
                          input logic [3:0] rdd, input logic [3:0] din);
        @(negedge clk);
        a_rst = r; a_hold = h; a_wr = w; a_rt = t;
        a_rs1 = r1; a_rs2 = r2; a_rd = rdd; a_in = din;
        #1;
    endtask

    localparam logic [31:0] W_DB = 32'hDEADBEEF;
    localparam logic [31:0] W_X0 = 32'h12345678;
    localparam logic [31:0] W_CF = 32'hCAFEF00D;
    localparam logic [31:0] W_35 = 32'h13579BDF;
    localparam logic [31:0] W_89 = 32'h89ABCDEF;
    localparam logic [31:0] W_55 = 32'h55AA1234;

    logic [31:0] val_b, val_c;

    initial begin
        a_rst = 1; a_hold = 0; a_wr = 0; a_rt = 0;
        a_rs1 = 0; a_rs2 = 0; a_rd = 0; a_in = 0;
        b_rst = 1; b_wr = 0; b_rs1 = 0; b_rd = 0; b_in = 0;
        c_rst = 1; c_wr = 0; c_rs1 = 0; c_rd = 0; c_in = 0;

        for (int k = 0; k < 8; k++) add(0, 0, 4'(k + 1), 4'(k + 8), 0, 0, 0, 0, k);
        for (int k = 0; k < 8; k++) add(1, 0, 5, 0, 5, dig(W_DB, k), 0, 0, k);
        for (int k = 0; k < 8; k++) add(0, 0, 5, 0, 0, 0, dig(W_DB, k), 0, k);
        for (int k = 0; k < 8; k++) add(1, 1, 0, 0, 0, dig(W_X0, k), 0, 0, k);
        for (int k = 0; k < 8; k++) add(0, 0, 0, 5, 0, 0, 0, dig(W_DB, k), k);
        for (int k = 0; k < 8; k++)
            add(1, 1, 3, 3, 3, dig(W_CF, k), dig(W_CF, k), dig(W_CF, k), k);
        for (int k = 0; k < 8; k++)
            add(1, 0, 3, 3, 3, dig(W_35, k), dig(W_CF, k), dig(W_CF, k), k);
        for (int k = 0; k < 8; k++) add(0, 0, 3, 5, 0, 0, dig(W_35, k), dig(W_DB, k), k);

        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            step_a(0, 0, tbl[i].wr, tbl[i].rt, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].din);
            chk("a_idx", i, 32'(a_idx), 32'(tbl[i].eidx));
            chk("a_rs1_out", i, 32'(a_o1), 32'(tbl[i].e1));
            chk("a_rs2_out", i, 32'(a_o2), 32'(tbl[i].e2));
            chk("a_word_start", i, 32'(a_start), 32'(tbl[i].eidx == 3'd0));
            chk("a_word_done", i, 32'(a_done), 32'(tbl[i].eidx == 3'd7));
        end

        // Hold in the middle of a write to x7, with garbage on rd_in while held.
        for (int k = 0; k < 2; k++) begin
            step_a(0, 0, 1, 0, 7, 0, 7, dig(W_89, k));
            chk("hold_pre_idx", k, 32'(a_idx), k);
        end
        for (int h = 0; h < 3; h++) begin
            step_a(0, 1, 1, 1, 7, 7, 7, 4'(h * 5 + 3));
            chk("hold_idx", h, 32'(a_idx), 2);
            chk("hold_rs1_out", h, 32'(a_o1), 0);
        end
        for (int k = 2; k < 8; k++) begin
            step_a(0, 0, 1, 0, 7, 0, 7, dig(W_89, k));
            chk("hold_post_idx", k, 32'(a_idx), k);
        end
        for (int k = 0; k < 8; k++) begin
            step_a(0, 0, 0, 0, 7, 0, 0, 0);
            chk("hold_x7_read", k, 32'(a_o1), 32'(dig(W_89, k)));
        end

        // Reset while x9 is half written.
        for (int k = 0; k < 4; k++) begin
            step_a(0, 0, 1, 0, 9, 5, 9, dig(W_55, k));
            chk("mrst_pre_idx", k, 32'(a_idx), k);
        end
        step_a(1, 0, 1, 0, 9, 5, 9, dig(W_55, 4));
        chk("mrst_at_idx", 4, 32'(a_idx), 4);
        for (int k = 0; k < 8; k++) begin
            step_a(0, 0, 0, 0, 9, 7, 0, 0);
            chk("mrst_idx", k, 32'(a_idx), k);
            chk("mrst_x9_read", k, 32'(a_o1), 0);
            chk("mrst_x7_read", k, 32'(a_o2), 0);
        end

        // DIGIT=1: 32-cycle word into x31.
        val_b = $urandom;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            b_rst = 0; b_wr = 1; b_rd = 31; b_rs1 = 31; b_in = val_b[k];
            #1;
            chk("b_idx", k, 32'(b_idx), k);
            chk("b_word_done", k, 32'(b_done), 32'(k == 31));
        end
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            b_wr = 0;
            #1;
            chk("b_x31_read", k, 32'(b_o1), 32'(val_b[k]));
        end

        // DIGIT=8: 4-cycle word into x31.
        val_c = $urandom;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            c_rst = 0; c_wr = 1; c_rd = 31; c_rs1 = 31; c_in = val_c[k*8 +: 8];
            #1;
            chk("c_idx", k, 32'(c_idx), k);
            chk("c_word_done", k, 32'(c_done), 32'(k == 3));
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            c_wr = 0;
            #1;
            chk("c_x31_read", k, 32'(c_o1), 32'(val_c[k*8 +: 8]));
            chk("c_x0_read", k, 32'(c_o2), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
